// File: rtl/apa102_shift_out.sv
// rtl/apa102_shift_out.sv - APA102 frame serializer paced by divider bit_clk ticks
module apa102_shift_out #(
    parameter int NUM_PIXELS = 8,
    parameter int END_BITS   = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        bit_clk,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [23:0] pix_rgb,
    input  logic [4:0]  pix_bright,
    output logic        led_clk,
    output logic        led_data,
    output logic        busy
);
    localparam int MAXB = (END_BITS > 32) ? END_BITS : 32;
    localparam int BW   = $clog2(MAXB);
    localparam int PW   = $clog2(NUM_PIXELS + 1);
    localparam logic [BW-1:0] FIELD_LAST = BW'(31);
    localparam logic [BW-1:0] END_LAST   = BW'(END_BITS - 1);
    localparam logic [PW-1:0] PIX_TOTAL  = PW'(NUM_PIXELS);

    if (NUM_PIXELS < 1) begin : g_bad_num_pixels
        $error("NUM_PIXELS must be at least 1");
    end
    if (END_BITS < (NUM_PIXELS + 1) / 2) begin : g_bad_end_bits
        $error("END_BITS must be at least ceil(NUM_PIXELS/2)");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_PIXEL, S_STALL, S_END} state_t;

    state_t          state_q, state_d;
    logic            bit_clk_q;
    logic            phase_q, phase_d;
    logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [PW-1:0]   pix_cnt_q, pix_cnt_d;
    logic [31:0]     shift_q, shift_d;
    logic            led_clk_q, led_clk_d;
    logic            led_data_q, led_data_d;
    logic            busy_q, busy_d;
    logic            tick, try_load, ready_c;
    logic [31:0]     word;

    assign tick = bit_clk & ~bit_clk_q;
    assign word = {3'b111, pix_bright, pix_rgb[7:0], pix_rgb[15:8], pix_rgb[23:16]};

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        bit_cnt_d  = bit_cnt_q;
        pix_cnt_d  = pix_cnt_q;
        shift_d    = shift_q;
        led_clk_d  = led_clk_q;
        led_data_d = led_data_q;
        busy_d     = busy_q;
        try_load   = 1'b0;
        ready_c    = 1'b0;
        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    if (pix_valid) begin
                        state_d    = S_START;
                        busy_d     = 1'b1;
                        phase_d    = 1'b0;
                        bit_cnt_d  = '0;
                        led_data_d = 1'b0;
                    end
                end
                S_STALL: try_load = 1'b1;
                S_START, S_PIXEL, S_END: begin
                    phase_d   = ~phase_q;
                    led_clk_d = ~phase_q;
                    if (phase_q) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        case (state_q)
                            S_START: begin
                                led_data_d = 1'b0;
                                if (bit_cnt_q == FIELD_LAST) try_load = 1'b1;
                            end
                            S_PIXEL: begin
                                led_data_d = shift_q[30];
                                shift_d    = shift_q << 1;
                                if (bit_cnt_q == FIELD_LAST) begin
                                    if (pix_cnt_q < PIX_TOTAL) begin
                                        try_load = 1'b1;
                                    end else begin
                                        state_d    = S_END;
                                        led_data_d = 1'b1;
                                        bit_cnt_d  = '0;
                                    end
                                end
                            end
                            default: begin
                                led_data_d = 1'b1;
                                if (bit_cnt_q == END_LAST) begin
                                    state_d    = S_IDLE;
                                    led_data_d = 1'b0;
                                    busy_d     = 1'b0;
                                    pix_cnt_d  = '0;
                                    bit_cnt_d  = '0;
                                end
                            end
                        endcase
                    end
                end
                default: state_d = S_IDLE;
            endcase
            // Underrun parks in STALL with the clock low; the strip only cares about rising edges.
            if (try_load) begin
                ready_c   = 1'b1;
                bit_cnt_d = '0;
                phase_d   = 1'b0;
                led_clk_d = 1'b0;
                if (pix_valid) begin
                    shift_d    = word;
                    led_data_d = 1'b1;
                    pix_cnt_d  = pix_cnt_q + 1'b1;
                    state_d    = S_PIXEL;
                end else begin
                    state_d    = S_STALL;
                    led_data_d = led_data_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        bit_clk_q <= bit_clk;
        if (!resetn) begin
            state_q    <= S_IDLE;
            phase_q    <= 1'b0;
            bit_cnt_q  <= '0;
            pix_cnt_q  <= '0;
            shift_q    <= '0;
            led_clk_q  <= 1'b0;
            led_data_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            bit_cnt_q  <= bit_cnt_d;
            pix_cnt_q  <= pix_cnt_d;
            shift_q    <= shift_d;
            led_clk_q  <= led_clk_d;
            led_data_q <= led_data_d;
            busy_q     <= busy_d;
        end
    end

    assign pix_ready = resetn & ready_c;
    assign led_clk   = led_clk_q;
    assign led_data  = led_data_q;
    assign busy      = busy_q;
endmodule
